// File: rtl/h80_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : h80_bus_arbiter
// Purpose  : Two-master round-robin arbiter for the shared H80 I/O/memory bus.
//            Each transfer keeps the grant until it finishes. If the other
//            master is waiting, the current owner can make at most BURST_LEN
//            back-to-back transfers before the grant moves to the other
//            master. The granted master's command is passed combinationally
//            onto the bus. The other master is stalled through its private
//            wait_n.
// Options  : H80_ARB_LOCK_EN - adds m0_lock/m1_lock. While the granted
//            master holds its lock, the grant does not move.
// Ports    : clk, reset (synchronous, active-high)
//            mN_num/addr/cmd/wr_data  master request inputs (N = 0, 1)
//            mN_rd_data               read data (copy of bus_data_)
//            mN_wait_n                master stall, 0 = hold request
//            mN_lock                  grant lock (H80_ARB_LOCK_EN only)
//            iorq_n_/mreq_n_          bus strobes, active low
//            bus_addr_/bus_cmd_       address and command of the granted master
//            bus_data_                bidirectional data, driven on writes
//            bus_wait_n               slave wait, 0 = extend the transfer
// Revision : 1.0 - initial release
// ============================================================================
module h80_bus_arbiter #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 16,
    parameter int BURST_LEN      = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      m0_num,
    input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m0_wr_data,
    output logic [BUS_DATA_WIDTH-1:0] m0_rd_data,
    output logic                      m0_wait_n,

    input  logic                      m1_num,
    input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
    input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
    input  logic [BUS_DATA_WIDTH-1:0] m1_wr_data,
    output logic [BUS_DATA_WIDTH-1:0] m1_rd_data,
    output logic                      m1_wait_n,

`ifdef H80_ARB_LOCK_EN
    input  logic                      m0_lock,
    input  logic                      m1_lock,
`endif

    output logic                      iorq_n_,
    output logic                      mreq_n_,
    output logic [BUS_ADDR_WIDTH-1:0] bus_addr_,
    output logic [BUS_CMD_WIDTH-1:0]  bus_cmd_,
    inout  wire  [BUS_DATA_WIDTH-1:0] bus_data_,
    input  logic                      bus_wait_n
);

    // H80 bus encoding: command 0 is idle, and bit 0 set marks a read.
    localparam logic [BUS_CMD_WIDTH-1:0] c_BUS_CMD_NONE = '0;
    localparam logic                     c_BUS_IO       = 1'b0;
    localparam logic                     c_BUS_MEM      = 1'b1;

    localparam int                 c_CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(BURST_LEN);

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_t;

    grant_t               r_grant;
    grant_t               w_grant_nxt;
    grant_t               w_grant_other;
    logic [c_CNT_W-1:0]   r_burst_cnt;
    logic [c_CNT_W-1:0]   w_burst_cnt_nxt;

    logic                      w_m0_req;
    logic                      w_m1_req;
    logic                      w_gnt_req;
    logic                      w_oth_req;
    logic                      w_gnt_lock;
    logic                      w_sel_num;
    logic [BUS_ADDR_WIDTH-1:0] w_sel_addr;
    logic [BUS_CMD_WIDTH-1:0]  w_sel_cmd;
    logic [BUS_DATA_WIDTH-1:0] w_sel_wr_data;
    logic                      w_bus_active;
    logic                      w_drive_data;

    assign w_m0_req = (m0_cmd != c_BUS_CMD_NONE);
    assign w_m1_req = (m1_cmd != c_BUS_CMD_NONE);

    assign w_gnt_req     = (r_grant == GNT_M1) ? w_m1_req : w_m0_req;
    assign w_oth_req     = (r_grant == GNT_M1) ? w_m0_req : w_m1_req;
    assign w_grant_other = (r_grant == GNT_M1) ? GNT_M0 : GNT_M1;

`ifdef H80_ARB_LOCK_EN
    // Only the current owner's lock counts. The other master cannot keep
    // the grant it does not have.
    assign w_gnt_lock = (r_grant == GNT_M1) ? m1_lock : m0_lock;
`else
    assign w_gnt_lock = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= GNT_M0;
            r_burst_cnt <= '0;
        end else begin
            r_grant     <= w_grant_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A transfer that is in progress (slave wait) never
    // changes the grant. Arbitration happens only on a completion or when
    // the owner is idle.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_nxt     = r_grant;
        w_burst_cnt_nxt = r_burst_cnt;
        if (w_gnt_req) begin
            if (bus_wait_n) begin
                if (!w_oth_req) begin
                    // Nobody is waiting, so the burst window restarts.
                    w_burst_cnt_nxt = '0;
                end else if (w_gnt_lock) begin
                    // The counter saturates so that the grant moves on the
                    // first completion after the lock is released.
                    if (r_burst_cnt != c_CNT_MAX) begin
                        w_burst_cnt_nxt = r_burst_cnt + c_CNT_ONE;
                    end
                end else if (r_burst_cnt >= c_CNT_LAST) begin
                    w_grant_nxt     = w_grant_other;
                    w_burst_cnt_nxt = '0;
                end else begin
                    w_burst_cnt_nxt = r_burst_cnt + c_CNT_ONE;
                end
            end
        end else if (w_oth_req && !w_gnt_lock) begin
            w_grant_nxt     = w_grant_other;
            w_burst_cnt_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Bus multiplexer. Reset forces the bus idle at once, so a transfer
    // that was in progress is dropped on the same cycle.
    // ------------------------------------------------------------------
    assign w_sel_num     = (r_grant == GNT_M1) ? m1_num     : m0_num;
    assign w_sel_addr    = (r_grant == GNT_M1) ? m1_addr    : m0_addr;
    assign w_sel_cmd     = (r_grant == GNT_M1) ? m1_cmd     : m0_cmd;
    assign w_sel_wr_data = (r_grant == GNT_M1) ? m1_wr_data : m0_wr_data;

    assign bus_addr_    = w_sel_addr;
    assign bus_cmd_     = reset ? c_BUS_CMD_NONE : w_sel_cmd;
    assign w_bus_active = (bus_cmd_ != c_BUS_CMD_NONE);

    assign iorq_n_ = !(w_bus_active && (w_sel_num == c_BUS_IO));
    assign mreq_n_ = !(w_bus_active && (w_sel_num == c_BUS_MEM));

    // Write data is driven only for a real write command. Otherwise the bus
    // is left free for the slave, or left floating when the bus is idle.
    assign w_drive_data = w_bus_active && !bus_cmd_[0];
    assign bus_data_    = w_drive_data ? w_sel_wr_data : {BUS_DATA_WIDTH{1'bz}};

    assign m0_rd_data = bus_data_;
    assign m1_rd_data = bus_data_;

    // The owner sees the slave wait directly. A master without the grant is
    // stalled only while it has a pending request.
    assign m0_wait_n = !reset && ((r_grant == GNT_M0) ? bus_wait_n : !w_m0_req);
    assign m1_wait_n = !reset && ((r_grant == GNT_M1) ? bus_wait_n : !w_m1_req);

endmodule
`default_nettype wire

// File: tb/tb_h80_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_h80_bus_arbiter
// Purpose  : Self-checking bench for h80_bus_arbiter. Directed scenarios are
//            followed by randomized traffic. A behavioural reference model
//            tracks ownership and the length of the current burst.
// Options  : H80_ARB_LOCK_EN - also exercises the lock inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_h80_bus_arbiter;

    localparam int AW = 16;
    localparam int CW = 3;
    localparam int DW = 16;
    localparam int BL = 4;

    localparam logic [CW-1:0] NONE = 3'd0;
    localparam logic [CW-1:0] RD_B = 3'd1;
    localparam logic [CW-1:0] WR_B = 3'd2;
    localparam logic [CW-1:0] RD_W = 3'd3;
    localparam logic [CW-1:0] WR_W = 3'd4;
    localparam logic          IO   = 1'b0;
    localparam logic          MEM  = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          m_num  [2];
    logic [AW-1:0] m_addr [2];
    logic [CW-1:0] m_cmd  [2];
    logic [DW-1:0] m_wr   [2];
    logic          m_lock [2];
    logic          bus_wait_n;
    logic [DW-1:0] slv_data;

    wire [DW-1:0] m0_rd_data;
    wire [DW-1:0] m1_rd_data;
    wire          m0_wait_n;
    wire          m1_wait_n;
    wire          iorq_n_;
    wire          mreq_n_;
    wire [AW-1:0] bus_addr_;
    wire [CW-1:0] bus_cmd_;
    wire [DW-1:0] bus_data_;

    // Slave model: returns slv_data whenever the bus carries a read.
    assign bus_data_ = (bus_cmd_ != NONE && bus_cmd_[0]) ? slv_data : {DW{1'bz}};

    h80_bus_arbiter #(
        .BUS_ADDR_WIDTH (AW),
        .BUS_CMD_WIDTH  (CW),
        .BUS_DATA_WIDTH (DW),
        .BURST_LEN      (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_num     (m_num[0]),
        .m0_addr    (m_addr[0]),
        .m0_cmd     (m_cmd[0]),
        .m0_wr_data (m_wr[0]),
        .m0_rd_data (m0_rd_data),
        .m0_wait_n  (m0_wait_n),
        .m1_num     (m_num[1]),
        .m1_addr    (m_addr[1]),
        .m1_cmd     (m_cmd[1]),
        .m1_wr_data (m_wr[1]),
        .m1_rd_data (m1_rd_data),
        .m1_wait_n  (m1_wait_n),
`ifdef H80_ARB_LOCK_EN
        .m0_lock    (m_lock[0]),
        .m1_lock    (m_lock[1]),
`endif
        .iorq_n_    (iorq_n_),
        .mreq_n_    (mreq_n_),
        .bus_addr_  (bus_addr_),
        .bus_cmd_   (bus_cmd_),
        .bus_data_  (bus_data_),
        .bus_wait_n (bus_wait_n)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int owner = 0;   // master currently holding the bus
    int run   = 0;   // completions in the current contended burst
    bit comp     [2];
    int obs_done [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int i, input logic [CW-1:0] c, input logic n,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_cmd[i]  = c;
        m_num[i]  = n;
        m_addr[i] = a;
        m_wr[i]   = d;
    endtask

    task automatic check_cycle();
        logic [CW-1:0] ec;
        logic          ew0;
        logic          ew1;
        ec  = reset ? NONE : m_cmd[owner];
        ew0 = reset ? 1'b0 : ((owner == 0) ? bus_wait_n : (m_cmd[0] == NONE));
        ew1 = reset ? 1'b0 : ((owner == 1) ? bus_wait_n : (m_cmd[1] == NONE));
        chk("bus_cmd", 32'(bus_cmd_), 32'(ec));
        chk("iorq_n",  32'(iorq_n_), 32'(!(ec != NONE && m_num[owner] == IO)));
        chk("mreq_n",  32'(mreq_n_), 32'(!(ec != NONE && m_num[owner] == MEM)));
        chk("m0_wait_n", 32'(m0_wait_n), 32'(ew0));
        chk("m1_wait_n", 32'(m1_wait_n), 32'(ew1));
        if (ec != NONE) chk("bus_addr", 32'(bus_addr_), 32'(m_addr[owner]));
        if (ec != NONE && !ec[0]) chk("bus_wdata", 32'(bus_data_), 32'(m_wr[owner]));
        if (ec != NONE && ec[0]) begin
            chk("m0_rd_data", 32'(m0_rd_data), 32'(slv_data));
            chk("m1_rd_data", 32'(m1_rd_data), 32'(slv_data));
        end
        comp[0] = ew0 && (m_cmd[0] != NONE);
        comp[1] = ew1 && (m_cmd[1] != NONE);
        // Completions as seen by the masters on the DUT outputs.
        if (m_cmd[0] != NONE && m0_wait_n === 1'b1) obs_done[0]++;
        if (m_cmd[1] != NONE && m1_wait_n === 1'b1) obs_done[1]++;
    endtask

    task automatic model_update();
        bit g;
        bit o;
        bit lk;
        if (reset) begin
            owner = 0;
            run   = 0;
        end else begin
            g  = (m_cmd[owner] != NONE);
            o  = (m_cmd[1 - owner] != NONE);
            lk = m_lock[owner];
            if (g && bus_wait_n) begin
                if (!o) run = 0;
                else if (lk) run = (run + 1 > BL) ? BL : run + 1;
                else if (run + 1 >= BL) begin
                    owner = 1 - owner;
                    run   = 0;
                end else run = run + 1;
            end else if (!g && o && !lk) begin
                owner = 1 - owner;
                run   = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic rand_step();
        for (int i = 0; i < 2; i++) begin
            if (m_cmd[i] == NONE || comp[i]) begin
                if ($urandom_range(0, 2) == 0) m_cmd[i] = NONE;
                else set_m(i, CW'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                           AW'($urandom), DW'($urandom));
            end
`ifdef H80_ARB_LOCK_EN
            m_lock[i] = ($urandom_range(0, 3) == 0);
`endif
        end
        bus_wait_n = ($urandom_range(0, 3) != 0);
        slv_data   = DW'($urandom);
        reset      = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        reset      = 1'b1;
        bus_wait_n = 1'b1;
        slv_data   = 16'h5A5A;
        m_lock[0]  = 1'b0;
        m_lock[1]  = 1'b0;
        obs_done[0] = 0;
        obs_done[1] = 0;
        comp[0] = 1'b0;
        comp[1] = 1'b0;

        // Reset with both masters requesting: the bus must stay idle.
        set_m(0, RD_B, IO,  16'h1234, 16'h1111);
        set_m(1, WR_B, MEM, 16'h4321, 16'h2222);
        tick();
        tick();

        // m0 read_b at 0x0001 is passed straight through.
        reset = 1'b0;
        set_m(0, RD_B, IO, 16'h0001, 16'h0000);
        set_m(1, NONE, IO, 16'h0000, 16'h0000);
        tick();

        // m1 write while the owner is idle: one penalty cycle, then granted.
        set_m(0, NONE, IO, 16'h0000, 16'h0000);
        set_m(1, WR_B, IO, 16'h0000, 16'h00AB);
        tick();
        tick();
        set_m(1, NONE, IO, 16'h0000, 16'h0000);

        // Continuous contention without slave waits gives bursts of 4 each.
        set_m(0, RD_W, MEM, 16'h0100, 16'h0000);
        set_m(1, WR_W, IO,  16'h0200, 16'hBEEF);
        obs_done[0] = 0;
        obs_done[1] = 0;
        for (int k = 0; k < 16; k++) tick();
        chk("burst_m0_done", 32'(obs_done[0]), 32'd8);
        chk("burst_m1_done", 32'(obs_done[1]), 32'd8);

        // m0 transfer held by the slave for 3 cycles while m1 requests.
        set_m(0, NONE, IO, 16'h0000, 16'h0000);
        set_m(1, NONE, IO, 16'h0000, 16'h0000);
        tick();
        set_m(0, RD_B, IO, 16'h0033, 16'h0000);
        tick();
        set_m(1, WR_B, MEM, 16'h0044, 16'h0055);
        bus_wait_n  = 1'b0;
        obs_done[1] = 0;
        for (int k = 0; k < 3; k++) tick();
        bus_wait_n = 1'b1;
        tick();
        chk("wait_m1_stalled", 32'(obs_done[1]), 32'd0);
        set_m(0, NONE, IO, 16'h0000, 16'h0000);
        tick();
        tick();

        // m1 memory read, then reset in the middle of the transfer.
        set_m(1, RD_B, MEM, 16'h0066, 16'h0000);
        bus_wait_n = 1'b0;
        slv_data   = 16'hC3C3;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        set_m(1, NONE, IO, 16'h0000, 16'h0000);
        bus_wait_n = 1'b1;
        tick();

`ifdef H80_ARB_LOCK_EN
        // m0 keeps the bus while it holds its lock.
        set_m(0, RD_W, IO, 16'h0077, 16'h0000);
        tick();
        tick();
        m_lock[0] = 1'b1;
        set_m(1, WR_W, IO, 16'h0088, 16'h0099);
        obs_done[0] = 0;
        obs_done[1] = 0;
        for (int k = 0; k < 10; k++) tick();
        chk("lock_m0_done", 32'(obs_done[0]), 32'd10);
        chk("lock_m1_done", 32'(obs_done[1]), 32'd0);
        m_lock[0] = 1'b0;
        tick();
        tick();
        chk("unlock_m1_done", 32'(obs_done[1]), 32'd1);
`endif

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rand_step();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/h80_bus_arbiter.md
# h80_bus_arbiter

Two-master arbiter for the H80 I/O/memory bus. Sits between two bus masters, such as the tiny CPU and a serial echo/DMA engine, and the single shared H80 bus (iorq_n_/mreq_n_/addr/cmd/data/wait_n). It grants the bus round-robin with a bounded burst, muxes the granted master onto the bus, and stalls the other master through its private wait_n. A preprocessor option adds a lock input for atomic multi-transfer sequences.

## Interface
- BUS_ADDR_WIDTH, 16, address width
- BUS_CMD_WIDTH, 3, command width (h80bus.svh encoding)
- BUS_DATA_WIDTH, 16, data width
- BURST_LEN, 4, max back-to-back transfers the owner keeps while the other master is requesting (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mN_num  in  1  per master N∈{0,1}: BUS_IO or BUS_MEM
- mN_addr  in  BUS_ADDR_WIDTH  master address
- mN_cmd  in  BUS_CMD_WIDTH  master command; ≠ bus_cmd_none is a request
- mN_wr_data  in  BUS_DATA_WIDTH  master write data
- mN_rd_data  out  BUS_DATA_WIDTH  read data (bus_data_ broadcast)
- mN_wait_n  out  1  master stall; 0 = hold cmd/addr/data
- mN_lock  in  1  only with H80_ARB_LOCK_EN: keep grant
- iorq_n_, mreq_n_  out  1  bus strobes
- bus_addr_  out  BUS_ADDR_WIDTH  muxed address
- bus_cmd_  out  BUS_CMD_WIDTH  muxed command
- bus_data_  inout  BUS_DATA_WIDTH  driven with granted wr_data when !bus_cmd_[0], else Z
- bus_wait_n  in  1  slave wait, 0 = extend transfer

## Operation
- Registers: grant (1 bit), burst_cnt ($clog2(BURST_LEN+1) bits).
- Reset: grant=0, burst_cnt=0; while reset is high: bus_cmd_=bus_cmd_none, iorq_n_=mreq_n_=1, bus_data_=Z, both mN_wait_n=0.
- Mux (combinational from grant): bus_addr_, bus_cmd_ and the num select come from master[grant]. iorq_n_ = !(num==BUS_IO && cmd!=none). mreq_n_ = !(num==BUS_MEM && cmd!=none).
- m[grant]_wait_n = bus_wait_n. The non-granted master's wait_n = 0 when its cmd≠none, 1 when it is idle.
- Transfer completes on a clk edge where the granted cmd≠none and bus_wait_n=1.
- Grant update at each edge:
  - Granted cmd≠none and bus_wait_n=0: hold grant and burst_cnt. A transfer is never split.
  - Transfer completes and the other master requests: if burst_cnt+1 ≥ BURST_LEN, switch grant and set burst_cnt=0. Otherwise keep grant and increment burst_cnt.
  - Transfer completes and the other master is idle: keep grant and set burst_cnt=0.
  - Granted master idle and the other master requests: switch grant and set burst_cnt=0.
  - Both idle: hold.
- The arbiter only reads mN_rd_data = bus_data_. The master samples it on its completing edge.

## Timing
- Owner transfer latency equals slave latency, with zero arbiter overhead. Commands are combinational pass-through.
- Non-owner request while the owner is idle: granted at the next edge, so a 1-cycle penalty. The bus carries bus_cmd_none during the penalty cycle.
- Contention worst case for a waiting master: BURST_LEN transfers plus wait states, plus 1 cycle.
- Reset mid-transfer: bus released at the same edge. Masters must reissue.

## Configuration
- H80_ARB_LOCK_EN defined: mN_lock ports exist. While m[grant]_lock=1, grant never switches and burst_cnt saturates; lock is ignored for the non-granted master.
- H80_ARB_LOCK_EN undefined: no lock ports. Arbitration is purely round-robin/burst as above.

## Test plan
- Reset, then m0 read_b at addr 0x0001 with bus_wait_n=1 → next cycle grant=0, bus_addr_=0x0001, iorq_n_=0, m0_wait_n=1, m1_wait_n=1.
- m0 idle, m1 write_b 0x00AB to addr 0x0000 (num=BUS_IO) → cycle 1: bus_cmd_=none and m1_wait_n=0. Cycle 2: bus_data_=0x00AB, iorq_n_=0, m1_wait_n=1.
- Both request continuously, BURST_LEN=4, no waits → grant pattern 0,0,0,0,1,1,1,1,0… and exactly 4 completions per owner.
- m0 read with bus_wait_n low for 3 cycles while m1 requests → grant stays 0 for 4 cycles and m1_wait_n=0 throughout. Switch happens only after completion per the burst rule.
- m1 MEM read → mreq_n_=0, iorq_n_=1, bus_data_=Z. Assert reset mid-transfer → bus_cmd_=none and grant=0 on the following edge.
- With H80_ARB_LOCK_EN: m0_lock=1, both requesting, 10 transfers → all 10 granted to m0. Drop lock → m1 granted after the next m0 completion.
